// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: parses a length/data/checksum byte frame,
// writes little-endian words to consecutive addresses and releases the core when verified.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  resetPC,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_t                stateReg, stateNext;
  logic [7:0]            lenLoReg, lenLoNext;
  logic [ADDR_WIDTH:0]   numWordsReg, numWordsNext;
  logic [ADDR_WIDTH:0]   wordIdxReg, wordIdxNext;
  logic [1:0]            byteCntReg, byteCntNext;
  logic [23:0]           wordBufReg, wordBufNext;
  logic [7:0]            csumReg, csumNext;
  logic                  weReg, weNext;
  logic [ADDR_WIDTH-1:0] addrReg, addrNext;
  logic [31:0]           wdataReg, wdataNext;
  logic                  holdReg, holdNext;
  logic                  doneReg, doneNext;
  logic                  errReg, errNext;

  logic                  accepting;
  logic                  xfer;
  logic [16:0]           lenFull;
  logic [ADDR_WIDTH:0]   wordIdxInc;
  logic [7:0]            csumSum;

  // Ready is gated by reset so the source never sees a transfer while held.
  assign accepting  = (stateReg == LEN0) || (stateReg == LEN1) ||
                      (stateReg == DATA) || (stateReg == CSUM);
  assign in_ready   = accepting && !resetPC;
  assign xfer       = in_valid && in_ready;
  assign lenFull    = {1'b0, in_data, lenLoReg};
  assign wordIdxInc = wordIdxReg + (ADDR_WIDTH+1)'(1);
  assign csumSum    = csumReg + in_data;

  always_ff @(posedge CLK) begin
    if (resetPC) begin
      stateReg    <= LEN0;
      lenLoReg    <= '0;
      numWordsReg <= '0;
      wordIdxReg  <= '0;
      byteCntReg  <= '0;
      wordBufReg  <= '0;
      csumReg     <= '0;
      weReg       <= 1'b0;
      addrReg     <= '0;
      wdataReg    <= '0;
      holdReg     <= 1'b1;
      doneReg     <= 1'b0;
      errReg      <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      lenLoReg    <= lenLoNext;
      numWordsReg <= numWordsNext;
      wordIdxReg  <= wordIdxNext;
      byteCntReg  <= byteCntNext;
      wordBufReg  <= wordBufNext;
      csumReg     <= csumNext;
      weReg       <= weNext;
      addrReg     <= addrNext;
      wdataReg    <= wdataNext;
      holdReg     <= holdNext;
      doneReg     <= doneNext;
      errReg      <= errNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    lenLoNext    = lenLoReg;
    numWordsNext = numWordsReg;
    wordIdxNext  = wordIdxReg;
    byteCntNext  = byteCntReg;
    wordBufNext  = wordBufReg;
    csumNext     = csumReg;
    weNext       = 1'b0;
    addrNext     = addrReg;
    wdataNext    = wdataReg;
    holdNext     = holdReg;
    doneNext     = doneReg;
    errNext      = errReg;

    if (xfer) begin
      case (stateReg)
        LEN0: begin
          lenLoNext = in_data;
          stateNext = LEN1;
        end
        LEN1: begin
          if (lenFull == 17'd0 || lenFull > MAX_WORDS) begin
            errNext   = 1'b1;
            stateNext = ERR;
          end else begin
            numWordsNext = lenFull[ADDR_WIDTH:0];
            stateNext    = DATA;
          end
        end
        DATA: begin
          csumNext    = csumSum;
          byteCntNext = byteCntReg + 2'd1;
          // Earlier bytes shift down so the first byte lands in bits [7:0].
          wordBufNext = {in_data, wordBufReg[23:8]};
          if (byteCntReg == 2'd3) begin
            weNext      = 1'b1;
            addrNext    = wordIdxReg[ADDR_WIDTH-1:0];
            wdataNext   = {in_data, wordBufReg};
            wordIdxNext = wordIdxInc;
            if (wordIdxInc == numWordsReg) stateNext = CSUM;
          end
        end
        CSUM: begin
          csumNext = csumSum;
          if (csumSum == 8'h00) begin
            doneNext  = 1'b1;
            holdNext  = 1'b0;
            stateNext = DONE;
          end else begin
            errNext   = 1'b1;
            stateNext = ERR;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_we    = weReg;
  assign imem_addr  = addrReg;
  assign imem_wdata = wdataReg;
  assign cpu_hold   = holdReg;
  assign done       = doneReg;
  assign error      = errReg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a small address space (16 words) so the
// full-capacity image stays short.
module tb_imem_loader;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          resetPC = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int tests = 0;
  int fails = 0;

  logic [31:0] img [0:31];
  logic [AW-1:0] wrAddr[$];
  logic [31:0]   wrData[$];
  int longPulse = 0;
  logic prevWe = 1'b0;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .resetPC(resetPC), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  // Write monitor sampled mid-cycle.
  always @(negedge CLK) begin
    if (imem_we) begin
      wrAddr.push_back(imem_addr);
      wrData.push_back(imem_wdata);
      $display("[TB] write addr=%0d data=%h", imem_addr, imem_wdata);
    end
    if (imem_we && prevWe) longPulse++;
    prevWe = imem_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic sendB(input logic [7:0] b, input bit gaps);
    if (gaps) idle($urandom_range(0, 2));
    in_valid = 1'b1;
    in_data  = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic sendImage(input int n, input int adj, input bit gaps);
    logic [7:0] sum;
    logic [7:0] byt;
    int nv;
    nv  = n;
    sum = 8'h00;
    sendB(nv[7:0], gaps);
    sendB(nv[15:8], gaps);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        byt = img[i][8*b +: 8];
        sum = sum + byt;
        sendB(byt, gaps);
      end
    end
    sendB(8'(8'h00 - sum + 8'(adj)), gaps);
  endtask

  task automatic doReset(input string tag);
    resetPC  = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk({tag, "_rdy"},   {31'd0, in_ready}, 32'd0);
    chk({tag, "_we"},    {31'd0, imem_we},  32'd0);
    chk({tag, "_addr"},  {28'd0, imem_addr}, 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_done"},  {31'd0, done},  32'd0);
    chk({tag, "_err"},   {31'd0, error}, 32'd0);
    resetPC = 1'b0;
    #1;
    chk({tag, "_rdy1"},  {31'd0, in_ready}, 32'd1);
    wrAddr.delete();
    wrData.delete();
  endtask

  task automatic chkWrites(input string tag, input int n);
    chk({tag, "_nwr"}, wrAddr.size(), n);
    for (int i = 0; i < n && i < wrAddr.size(); i++) begin
      chk($sformatf("%s_a%0d", tag, i), {28'd0, wrAddr[i]}, i);
      chk($sformatf("%s_d%0d", tag, i), wrData[i], img[i]);
    end
  endtask

  initial begin
    // Test 1: N=1 literal frame, continuous valid; checksum back-to-back with last data byte.
    doReset("rst0");
    sendB(8'h01, 0); sendB(8'h00, 0);
    sendB(8'h13, 0); sendB(8'h00, 0); sendB(8'h00, 0); sendB(8'h00, 0);
    chk("t1_we",    {31'd0, imem_we}, 32'd1);
    chk("t1_addr",  {28'd0, imem_addr}, 32'd0);
    chk("t1_wdata", imem_wdata, 32'h00000013);
    chk("t1_done0", {31'd0, done}, 32'd0);
    sendB(8'hED, 0);
    chk("t1_done",  {31'd0, done}, 32'd1);
    chk("t1_hold",  {31'd0, cpu_hold}, 32'd0);
    chk("t1_rdy",   {31'd0, in_ready}, 32'd0);
    chk("t1_we0",   {31'd0, imem_we}, 32'd0);
    idle(2);
    img[0] = 32'h00000013;
    chkWrites("t1", 1);

    // Test 2: N=3 with random valid gaps.
    doReset("rst2");
    img[0] = 32'h00500093; img[1] = 32'h00100113; img[2] = 32'h002081B3;
    sendImage(3, 0, 1);
    idle(2);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_err",  {31'd0, error}, 32'd0);
    chkWrites("t2", 3);

    // Test 3: N=2 with bad checksum; later bytes ignored.
    doReset("rst3");
    img[0] = 32'hDEADBEEF; img[1] = 32'h12345678;
    sendImage(2, 1, 0);
    chk("t3_err",  {31'd0, error}, 32'd1);
    chk("t3_done", {31'd0, done}, 32'd0);
    chk("t3_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t3_rdy",  {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 8; i++) sendB(8'(i), 0);
    idle(2);
    chkWrites("t3", 2);

    // Test 4a: zero length.
    doReset("rst4a");
    sendB(8'h00, 0); sendB(8'h00, 0);
    chk("t4a_err", {31'd0, error}, 32'd1);
    chk("t4a_rdy", {31'd0, in_ready}, 32'd0);
    idle(2);
    chk("t4a_nwr", wrAddr.size(), 0);

    // Test 4b: length one beyond capacity.
    doReset("rst4b");
    sendB(8'h11, 0); sendB(8'h00, 0);
    chk("t4b_err", {31'd0, error}, 32'd1);
    idle(2);
    chk("t4b_nwr", wrAddr.size(), 0);

    // Test 4c: full-capacity image.
    doReset("rst4c");
    for (int i = 0; i < 16; i++) img[i] = 32'hA0000000 + 32'(i * 32'h01010101);
    sendImage(16, 0, 0);
    chk("t4c_done", {31'd0, done}, 32'd1);
    chk("t4c_lastaddr", {28'd0, imem_addr}, 32'd15);
    idle(2);
    chkWrites("t4c", 16);

    // Test 5: reset after 6 data bytes of N=2, then a fresh N=1 frame.
    doReset("rst5");
    sendB(8'h02, 0); sendB(8'h00, 0);
    sendB(8'h11, 0); sendB(8'h22, 0); sendB(8'h33, 0); sendB(8'h44, 0);
    sendB(8'h55, 0); sendB(8'h66, 0);
    idle(1);
    chk("t5_nwr", wrAddr.size(), 1);
    if (wrData.size() > 0) chk("t5_d0", wrData[0], 32'h44332211);
    doReset("rst5b");
    img[0] = 32'hCAFEF00D;
    sendImage(1, 0, 0);
    idle(2);
    chk("t5_done", {31'd0, done}, 32'd1);
    chkWrites("t5", 1);

    chk("pulse_width", longPulse, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
